// File: rtl/axi_regfile_pkg.sv
// Shared types and helpers for the AXI / local register-file port arbiter.
// Holds the response FSM encoding and the word-address width computation.
package axi_regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    RRESP = 1'b1
  } arb_state_e;

  // Word-address width: drop the byte-offset bits implied by the data width.
  function automatic int calc_maw(input int addr_width, input int data_width);
    return addr_width - ($clog2(data_width) - 3);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
// Used for both the consecutive-wait counter and the conflict counter.
module sat_counter #(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/axi_regfile_arbiter.sv
// Shares a register file between an unstallable AXI side and a local requester.
// AXI owns each port outright; the local side gets leftover cycles plus starvation stats.
module axi_regfile_arbiter
  import axi_regfile_pkg::*;
#(
  parameter int  C_S_AXI_DATA_WIDTH = 32,
  parameter int  C_S_AXI_ADDR_WIDTH = 11,
  parameter int  MAX_WAIT           = 15,
  localparam int DW                 = C_S_AXI_DATA_WIDTH,
  localparam int NB                 = DW / 8,
  localparam int MAW                = calc_maw(C_S_AXI_ADDR_WIDTH, C_S_AXI_DATA_WIDTH)
) (
  input  logic           S_AXI_ACLK,
  input  logic           S_AXI_ARESET,
  // AXI side
  input  logic [MAW-1:0] axi_mem_wrAddr,
  input  logic [DW-1:0]  axi_mem_wdata,
  input  logic [NB-1:0]  axi_mem_wrByteStrobe,
  input  logic [MAW-1:0] axi_mem_rdAddr,
  input  logic           axi_mem_rdStrobe,
  output logic [DW-1:0]  axi_mem_rdata,
  // local side
  input  logic           lcl_req,
  input  logic           lcl_we,
  input  logic [MAW-1:0] lcl_addr,
  input  logic [DW-1:0]  lcl_wdata,
  input  logic [NB-1:0]  lcl_wstrb,
  output logic           lcl_gnt,
  output logic           lcl_rvalid,
  output logic [DW-1:0]  lcl_rdata,
  // register-file ports
  output logic [MAW-1:0] mem_wrAddr,
  output logic [DW-1:0]  mem_wdata,
  output logic [NB-1:0]  mem_wstrb,
  output logic [MAW-1:0] mem_rdAddr,
  output logic           mem_rd,
  input  logic [DW-1:0]  mem_rdata,
  // statistics
  input  logic           stat_clr,
  output logic           lcl_starve,
  output logic [15:0]    conflict_cnt
);

  localparam int               WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q;
  arb_state_e        state_d;
  logic [DW-1:0]     lcl_rdata_q;
  logic [DW-1:0]     lcl_rdata_d;
  logic              starve_q;
  logic              starve_d;

  logic              axi_wr;
  logic              resp_busy;
  logic              gnt;
  logic              lcl_wr_gnt;
  logic              lcl_rd_gnt;
  logic              blocked;
  logic [WAIT_W-1:0] wait_cnt;

  // Grant and port steering; reset masks every strobe the register file could act on.
  always_comb begin
    axi_wr     = |axi_mem_wrByteStrobe;
    resp_busy  = (state_q == RRESP);
    gnt        = ~S_AXI_ARESET & lcl_req & ~resp_busy &
                 (lcl_we ? ~axi_wr : ~axi_mem_rdStrobe);
    lcl_wr_gnt = gnt & lcl_we;
    lcl_rd_gnt = gnt & ~lcl_we;
    blocked    = lcl_req & ~gnt;

    mem_wrAddr = axi_mem_wrAddr;
    mem_wdata  = axi_mem_wdata;
    mem_wstrb  = '0;
    if (!S_AXI_ARESET) begin
      if (axi_wr) begin
        mem_wstrb = axi_mem_wrByteStrobe;
      end else if (lcl_wr_gnt) begin
        mem_wrAddr = lcl_addr;
        mem_wdata  = lcl_wdata;
        mem_wstrb  = lcl_wstrb;
      end
    end

    mem_rdAddr = (!axi_mem_rdStrobe && lcl_rd_gnt) ? lcl_addr : axi_mem_rdAddr;
    mem_rd     = ~S_AXI_ARESET & (axi_mem_rdStrobe | lcl_rd_gnt);
  end

  // Response FSM: one RRESP cycle per granted local read.
  always_comb begin
    state_d     = IDLE;
    lcl_rdata_d = lcl_rdata_q;
    case (state_q)
      IDLE: begin
        if (lcl_rd_gnt) begin
          state_d     = RRESP;
          lcl_rdata_d = mem_rdata;
        end
      end
      RRESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Starvation latches on the same edge that the wait count reaches its limit.
  always_comb begin
    starve_d = starve_q;
    if (stat_clr) begin
      starve_d = 1'b0;
    end else if (blocked && (wait_cnt >= (WAIT_LIMIT - 1'b1))) begin
      starve_d = 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q     <= IDLE;
      lcl_rdata_q <= '0;
      starve_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lcl_rdata_q <= lcl_rdata_d;
      starve_q    <= starve_d;
    end
  end

  sat_counter #(
    .WIDTH (WAIT_W),
    .LIMIT (WAIT_LIMIT)
  ) u_wait_cnt (
    .clk (S_AXI_ACLK),
    .rst (S_AXI_ARESET),
    .clr (~blocked),
    .inc (blocked),
    .cnt (wait_cnt)
  );

  sat_counter #(
    .WIDTH (16),
    .LIMIT (16'hFFFF)
  ) u_conflict_cnt (
    .clk (S_AXI_ACLK),
    .rst (S_AXI_ARESET),
    .clr (stat_clr),
    .inc (blocked),
    .cnt (conflict_cnt)
  );

  assign axi_mem_rdata = mem_rdata;
  assign lcl_gnt       = gnt;
  assign lcl_rvalid    = (state_q == RRESP);
  assign lcl_rdata     = lcl_rdata_q;
  assign lcl_starve    = starve_q;

endmodule
